counter_input_ctrl: RTL and testbench

//   Upstream control stage for the up/down counter. Conditions two raw board push-buttons
//   (debounce, synchronise, press-detect) and drives the counter's enable and countDirection.
//   The run button toggles free-running mode. While running, enable is a one-cycle tick every

---
 rtl/counter_pkg.sv | 16 +
 rtl/button_debouncer.sv | 71 +++++++
 rtl/counter_input_ctrl.sv | 100 ++++++++++
 tb/tb_counter_input_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and state encoding for the counter input control stage.
package counter_pkg;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 120_000;     // 10 ms at 12 MHz
  localparam int DEFAULT_TICK_DIVISOR    = 12_000_000;  // 1 Hz at 12 MHz

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/button_debouncer.sv
// Synchronises, debounces and press-detects one raw push-button.
module button_debouncer
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetN,
  input  logic btnIn,
  output logic level,
  output logic press
);
  timeunit 1ns;
  timeprecision 100ps;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  // fill_q[1] marks that the synchroniser now carries a real pin sample
  logic [1:0]       fill_q, fill_d;
  // armed_q is set once the button has been seen released after reset, so a
  // button held through reset release cannot produce a press
  logic             armed_q, armed_d;

  // Next-state: synchroniser shift, stability counter, press edge detect.
  always_comb begin
    sync_d  = {sync_q[0], btnIn};
    fill_d  = {fill_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = {CNT_W{1'b0}};
    prev_d  = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    armed_d = armed_q | (fill_q[1] & ~level_q & ~sync_q[1]);
    press_d = armed_q & level_q & ~prev_q;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_q  <= 2'b00;
      fill_q  <= 2'b00;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      press_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      armed_q <= armed_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
endmodule

// File: rtl/counter_input_ctrl.sv
// Run/stop and direction control for the up/down counter: two debounced
// buttons, a run/idle FSM, the enable prescaler and the direction register.
module counter_input_ctrl
  import counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TICK_DIVISOR    = DEFAULT_TICK_DIVISOR
) (
  input  logic clk,
  input  logic resetN,
  input  logic btnRun,
  input  logic btnDir,
  output logic enable,
  output logic countDirection,
  output logic running
);
  timeunit 1ns;
  timeprecision 100ps;

  localparam int P_W = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;

  logic        run_press_s, dir_press_s;
  logic        run_level_unused, dir_level_unused;
  ctrl_state_e state_q, state_d;
  logic [P_W-1:0] prescale_q, prescale_d;
  logic        enable_q, enable_d;
  logic        dir_q, dir_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .clk   (clk),
    .resetN(resetN),
    .btnIn (btnRun),
    .level (run_level_unused),
    .press (run_press_s)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_btn (
    .clk   (clk),
    .resetN(resetN),
    .btnIn (btnDir),
    .level (dir_level_unused),
    .press (dir_press_s)
  );

  // Next-state: run/idle toggle, prescaler wrap producing the enable tick, direction toggle.
  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    enable_d   = 1'b0;
    if (dir_press_s) begin
      dir_d = ~dir_q;
    end else begin
      dir_d = dir_q;
    end
    case (state_q)
      ST_IDLE: begin
        prescale_d = {P_W{1'b0}};
        if (run_press_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (run_press_s) begin
          state_d    = ST_IDLE;
          prescale_d = {P_W{1'b0}};
        end else if (prescale_q == P_W'(TICK_DIVISOR - 1)) begin
          prescale_d = {P_W{1'b0}};
          enable_d   = 1'b1;
        end else begin
          prescale_d = prescale_q + P_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        prescale_d = {P_W{1'b0}};
      end
    endcase
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      prescale_q <= {P_W{1'b0}};
      enable_q   <= 1'b0;
      dir_q      <= DIR_UP;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      enable_q   <= enable_d;
      dir_q      <= dir_d;
    end
  end

  assign enable         = enable_q;
  assign countDirection = dir_q;
  assign running        = (state_q == ST_RUN);
endmodule

// File: tb/tb_counter_input_ctrl.sv
// Randomised and directed bench for counter_input_ctrl against a timeline model.
module tb_counter_input_ctrl;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int DB   = 4;
  localparam int TD_A = 3;
  localparam int TD_B = 1;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic btnRun = 1'b0;
  logic btnDir = 1'b0;
  logic en_a, dir_a, run_a, en_b, dir_b, run_b;

  always #1 clk = ~clk;

  counter_input_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIVISOR(TD_A)) dut_a (
    .clk(clk), .resetN(resetN), .btnRun(btnRun), .btnDir(btnDir),
    .enable(en_a), .countDirection(dir_a), .running(run_a)
  );

  counter_input_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIVISOR(TD_B)) dut_b (
    .clk(clk), .resetN(resetN), .btnRun(btnRun), .btnDir(btnDir),
    .enable(en_b), .countDirection(dir_b), .running(run_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: raw-pin sample history per button, press timeline, run/dir state.
  logic       samp [2][8];
  logic       lvl [2];
  logic       armed [2];
  logic [1:0] pipe [2];
  int         since;
  int         ecount;
  logic       m_run [2];
  logic       m_dir [2];
  logic       m_en [2];
  int         start [2];
  int         td [2];

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) samp[b][i] = 1'b0;
      lvl[b] = 1'b0; armed[b] = 1'b0; pipe[b] = 2'b00;
      m_run[b] = 1'b0; m_dir[b] = 1'b1; m_en[b] = 1'b0; start[b] = 0;
    end
    since = 0;
  endtask

  task automatic model_edge();
    logic pin [2];
    logic evt [2];
    logic flip, newp;
    pin[0] = btnRun;
    pin[1] = btnDir;
    ecount++;
    if (since < 100) since++;
    for (int b = 0; b < 2; b++) begin
      evt[b] = pipe[b][1];
      for (int i = 7; i > 0; i--) samp[b][i] = samp[b][i-1];
      samp[b][0] = pin[b];
      // level flips once DB consecutive synchronised samples disagree with it
      flip = 1'b1;
      for (int i = 2; i <= DB + 1; i++) if (samp[b][i] == lvl[b]) flip = 1'b0;
      newp = flip && !lvl[b] && armed[b];
      if (since >= 3 && !lvl[b] && !samp[b][2]) armed[b] = 1'b1;
      if (flip) lvl[b] = ~lvl[b];
      pipe[b] = {pipe[b][0], newp};
    end
    for (int k = 0; k < 2; k++) begin
      m_en[k] = 1'b0;
      if (m_run[k] && !evt[0]) m_en[k] = (((ecount - start[k]) % td[k]) == 0);
      if (evt[0]) begin
        m_run[k] = ~m_run[k];
        start[k] = ecount;
      end
      if (evt[1]) m_dir[k] = ~m_dir[k];
    end
  endtask

  task automatic check_outputs();
    check_val("en_a",  en_a,  m_en[0]);
    check_val("dir_a", dir_a, m_dir[0]);
    check_val("run_a", run_a, m_run[0]);
    check_val("en_b",  en_b,  m_en[1]);
    check_val("dir_b", dir_b, m_dir[1]);
    check_val("run_b", run_b, m_run[1]);
  endtask

  // One clock: inputs already set after a falling edge; model advances on the rising edge.
  task automatic step();
    @(posedge clk);
    if (!resetN) model_reset();
    else model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int k0, lat, ticks, cnt_r, cnt_d;
    logic seen;
    td[0] = TD_A;
    td[1] = TD_B;
    ecount = 0;
    model_reset();
    @(negedge clk);

    // Reset held with buttons toggling
    for (int i = 0; i < 6; i++) begin
      btnRun = 1'($urandom_range(0, 1));
      btnDir = 1'($urandom_range(0, 1));
      step();
    end
    btnRun = 1'b0; btnDir = 1'b0; resetN = 1'b1;
    repeat (6) step();

    // Bounce rejection: 1, 2, 3 cycle pulses
    for (int w = 1; w <= 3; w++) begin
      btnRun = 1'b1;
      repeat (w) step();
      btnRun = 1'b0;
      repeat (6) step();
    end
    check_val("bounce_run", run_a, 1'b0);

    // Genuine press: running must rise exactly DB+3 edges after the first high sample
    btnRun = 1'b1;
    k0 = ecount + 1;
    lat = -1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) btnRun = 1'b0;
      step();
      if (run_a === 1'b1 && !seen) begin
        seen = 1'b1;
        lat = ecount - k0;
      end
    end
    check_val("run_latency", lat, DB + 3);

    // Tick cadence: ten ticks in thirty cycles
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (en_a === 1'b1) ticks++;
    end
    check_val("tick_count", ticks, 10);

    // Two direction presses while running
    for (int p = 0; p < 2; p++) begin
      btnDir = 1'b1;
      repeat (6) step();
      btnDir = 1'b0;
      repeat (6) step();
      check_val("dir_toggle", dir_a, (p == 0) ? 1'b0 : 1'b1);
    end

    // Stop
    btnRun = 1'b1;
    repeat (6) step();
    btnRun = 1'b0;
    repeat (6) step();
    check_val("stopped", run_a, 1'b0);

    // Simultaneous presses from idle
    btnRun = 1'b1; btnDir = 1'b1;
    repeat (6) step();
    btnRun = 1'b0; btnDir = 1'b0;
    repeat (6) step();
    check_val("simul_run", run_a, 1'b1);
    check_val("simul_dir", dir_a, 1'b0);

    // Reset mid-run with the run button held through release
    resetN = 1'b0;
    btnRun = 1'b1;
    model_reset();
    #0.5;
    check_val("rst_en",  en_a,  1'b0);
    check_val("rst_dir", dir_a, 1'b1);
    check_val("rst_run", run_a, 1'b0);
    step();
    resetN = 1'b1;
    repeat (12) step();
    check_val("held_no_restart", run_a, 1'b0);
    btnRun = 1'b0;
    repeat (8) step();
    btnRun = 1'b1;
    repeat (6) step();
    btnRun = 1'b0;
    repeat (6) step();
    check_val("repress_run", run_a, 1'b1);

    // Random button activity with occasional resets
    cnt_r = 0;
    cnt_d = 0;
    for (int i = 0; i < 800; i++) begin
      if (cnt_r == 0) begin
        btnRun = 1'($urandom_range(0, 1));
        cnt_r = $urandom_range(1, 9);
      end
      if (cnt_d == 0) begin
        btnDir = 1'($urandom_range(0, 1));
        cnt_d = $urandom_range(1, 9);
      end
      cnt_r--;
      cnt_d--;
      if ($urandom_range(0, 199) == 0) begin
        resetN = 1'b0;
        model_reset();
        step();
        resetN = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
